// File: rtl/cache_types_pkg.sv
// ============================================================================
// Module      : cache_types_pkg
// Description : Shared types and mux-select encodings for the cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        REFILL    = 3'd4
    } state_t;

    // Data-array write-enable source: whole-line fill or CPU byte write per way.
    localparam logic [2:0] c_we_none  = 3'b000;
    localparam logic [2:0] c_we_line0 = 3'b001;
    localparam logic [2:0] c_we_line1 = 3'b010;
    localparam logic [2:0] c_we_byte0 = 3'b101;
    localparam logic [2:0] c_we_byte1 = 3'b110;

    localparam logic [1:0] c_lo_none  = 2'b00;
    localparam logic [1:0] c_lo_way0  = 2'b01;
    localparam logic [1:0] c_lo_way1  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/cache_control.sv
// ============================================================================
// Module      : cache_control
// Description : Two-way write-back cache controller FSM with pipelined hits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_control
    import cache_types_pkg::*;
#(
    parameter int s_index  = 3,
    parameter int s_tag    = 24,
    parameter int s_offset = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 mem_read_reg_out,
    input  logic                 mem_write_reg_out,
    input  logic [31:0]          mem_address_reg_out,
    input  logic [s_index-1:0]   index_reg_out,
    input  logic [1:0]           hit,
    input  logic [1:0]           dirty_out,
    input  logic                 lru_out,
    input  logic [2*s_tag-1:0]   tag_out,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic                 load_stage,
    output logic                 rindex_mux_sel,
    output logic [1:0]           data_read_in,
    output logic [1:0]           tag_read_in,
    output logic [1:0]           valid_read_in,
    output logic [1:0]           dirty_read_in,
    output logic                 lru_read_in,
    output logic [1:0]           load_tag,
    output logic [1:0]           load_valid,
    output logic [1:0]           load_dirty,
    output logic                 load_lru,
    output logic                 lru_in,
    output logic                 line_in_mux_sel,
    output logic [1:0]           line_out_mux_sel,
    output logic                 dirty_in_mux_sel,
    output logic                 pmem_wdata_mux_sel,
    output logic [2:0]           write_en_mux_sel
);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_new_req;
    logic               w_victim;
    logic [1:0]         w_victim_mask;
    logic               w_hit_way;
    logic [1:0]         w_hit_mask;
    logic [s_tag-1:0]   w_victim_tag;
    logic               w_unused_offset;

    assign data_read_in  = 2'b11;
    assign tag_read_in   = 2'b11;
    assign valid_read_in = 2'b11;
    assign dirty_read_in = 2'b11;
    assign lru_read_in   = 1'b1;

    // LRU is never updated during a miss, so lru_out names the victim until refill.
    assign w_new_req     = mem_read | mem_write;
    assign w_victim      = lru_out;
    assign w_victim_mask = w_victim ? 2'b10 : 2'b01;
    assign w_victim_tag  = w_victim ? tag_out[2*s_tag-1:s_tag] : tag_out[s_tag-1:0];
    assign w_hit_way     = ~hit[0];
    assign w_hit_mask    = w_hit_way ? 2'b10 : 2'b01;
    assign w_unused_offset = ^mem_address_reg_out[s_offset-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        mem_resp           = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        pmem_address       = '0;
        load_stage         = 1'b0;
        rindex_mux_sel     = 1'b0;
        load_tag           = 2'b00;
        load_valid         = 2'b00;
        load_dirty         = 2'b00;
        load_lru           = 1'b0;
        lru_in             = 1'b0;
        line_in_mux_sel    = 1'b0;
        line_out_mux_sel   = c_lo_none;
        dirty_in_mux_sel   = 1'b0;
        pmem_wdata_mux_sel = 1'b0;
        write_en_mux_sel   = c_we_none;

        case (r_state)
            IDLE: begin
                load_stage = w_new_req;
                if (w_new_req) begin
                    w_next_state = COMPARE;
                end
            end

            COMPARE: begin
                if (|hit) begin
                    // Hit: respond now and accept the next request in the same cycle.
                    mem_resp     = 1'b1;
                    load_lru     = 1'b1;
                    lru_in       = hit[0];
                    load_stage   = w_new_req;
                    w_next_state = w_new_req ? COMPARE : IDLE;
                    if (mem_write_reg_out) begin
                        write_en_mux_sel = w_hit_way ? c_we_byte1 : c_we_byte0;
                        load_dirty       = w_hit_mask;
                        dirty_in_mux_sel = 1'b1;
                    end else if (mem_read_reg_out) begin
                        line_out_mux_sel = w_hit_way ? c_lo_way1 : c_lo_way0;
                    end
                end else begin
                    rindex_mux_sel = 1'b1;
                    w_next_state   = dirty_out[w_victim] ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                rindex_mux_sel     = 1'b1;
                pmem_write         = 1'b1;
                pmem_wdata_mux_sel = w_victim;
                pmem_address       = {w_victim_tag, index_reg_out, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    w_next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                rindex_mux_sel = 1'b1;
                pmem_read      = 1'b1;
                pmem_address   = {mem_address_reg_out[31:s_offset], {s_offset{1'b0}}};
                if (pmem_resp) begin
                    line_in_mux_sel  = 1'b1;
                    write_en_mux_sel = w_victim ? c_we_line1 : c_we_line0;
                    load_tag         = w_victim_mask;
                    load_valid       = w_victim_mask;
                    load_dirty       = w_victim_mask;
                    dirty_in_mux_sel = 1'b0;
                    w_next_state     = REFILL;
                end
            end

            REFILL: begin
                rindex_mux_sel = 1'b1;
                w_next_state   = COMPARE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_control.sv
// ============================================================================
// Module      : tb_cache_control
// Description : Table-driven, scoreboarded bench for cache_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_control;

    typedef struct packed {
        logic        rst;
        logic        mem_read;
        logic        mem_write;
        logic        rd_reg;
        logic        wr_reg;
        logic [31:0] addr;
        logic [2:0]  idx;
        logic [1:0]  hit;
        logic [1:0]  dirty;
        logic        lru;
        logic [23:0] tag0;
        logic [23:0] tag1;
        logic        pmem_resp;
    } ins_t;

    typedef struct packed {
        logic        mem_resp;
        logic        pmem_read;
        logic        pmem_write;
        logic [31:0] pmem_address;
        logic        load_stage;
        logic        rindex_mux_sel;
        logic [1:0]  load_tag;
        logic [1:0]  load_valid;
        logic [1:0]  load_dirty;
        logic        load_lru;
        logic        lru_in;
        logic        line_in_mux_sel;
        logic [1:0]  line_out_mux_sel;
        logic        dirty_in_mux_sel;
        logic        pmem_wdata_mux_sel;
        logic [2:0]  write_en_mux_sel;
        logic [1:0]  data_read_in;
        logic [1:0]  tag_read_in;
        logic [1:0]  valid_read_in;
        logic [1:0]  dirty_read_in;
        logic        lru_read_in;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write, mem_read_reg_out, mem_write_reg_out;
    logic [31:0] mem_address_reg_out;
    logic [2:0]  index_reg_out;
    logic [1:0]  hit, dirty_out;
    logic        lru_out;
    logic [47:0] tag_out;
    logic        pmem_resp;
    logic        mem_resp, pmem_read, pmem_write;
    logic [31:0] pmem_address;
    logic        load_stage, rindex_mux_sel;
    logic [1:0]  data_read_in, tag_read_in, valid_read_in, dirty_read_in;
    logic        lru_read_in;
    logic [1:0]  load_tag, load_valid, load_dirty;
    logic        load_lru, lru_in, line_in_mux_sel;
    logic [1:0]  line_out_mux_sel;
    logic        dirty_in_mux_sel, pmem_wdata_mux_sel;
    logic [2:0]  write_en_mux_sel;

    outs_t       act;
    vec_t        vecs[$];
    string       names[$];
    outs_t       sb[$];
    int          tests = 0;
    int          fails = 0;

    cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_reg_out(mem_read_reg_out), .mem_write_reg_out(mem_write_reg_out),
        .mem_address_reg_out(mem_address_reg_out), .index_reg_out(index_reg_out),
        .hit(hit), .dirty_out(dirty_out), .lru_out(lru_out), .tag_out(tag_out),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .load_stage(load_stage), .rindex_mux_sel(rindex_mux_sel),
        .data_read_in(data_read_in), .tag_read_in(tag_read_in),
        .valid_read_in(valid_read_in), .dirty_read_in(dirty_read_in),
        .lru_read_in(lru_read_in), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .load_lru(load_lru), .lru_in(lru_in),
        .line_in_mux_sel(line_in_mux_sel), .line_out_mux_sel(line_out_mux_sel),
        .dirty_in_mux_sel(dirty_in_mux_sel), .pmem_wdata_mux_sel(pmem_wdata_mux_sel),
        .write_en_mux_sel(write_en_mux_sel)
    );

    assign act = {mem_resp, pmem_read, pmem_write, pmem_address, load_stage,
                  rindex_mux_sel, load_tag, load_valid, load_dirty, load_lru, lru_in,
                  line_in_mux_sel, line_out_mux_sel, dirty_in_mux_sel,
                  pmem_wdata_mux_sel, write_en_mux_sel, data_read_in, tag_read_in,
                  valid_read_in, dirty_read_in, lru_read_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic outs_t e_base();
        outs_t o = '0;
        o.data_read_in  = 2'b11;
        o.tag_read_in   = 2'b11;
        o.valid_read_in = 2'b11;
        o.dirty_read_in = 2'b11;
        o.lru_read_in   = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_stage();
        outs_t o = e_base();
        o.load_stage = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_miss();
        outs_t o = e_base();
        o.rindex_mux_sel = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_alloc(input logic [31:0] a);
        outs_t o = e_miss();
        o.pmem_read    = 1'b1;
        o.pmem_address = a;
        return o;
    endfunction

    function automatic outs_t e_fill(input logic [31:0] a, input logic way);
        outs_t o = e_alloc(a);
        o.line_in_mux_sel  = 1'b1;
        o.write_en_mux_sel = way ? 3'b010 : 3'b001;
        o.load_tag         = way ? 2'b10 : 2'b01;
        o.load_valid       = way ? 2'b10 : 2'b01;
        o.load_dirty       = way ? 2'b10 : 2'b01;
        return o;
    endfunction

    function automatic outs_t e_wb(input logic [31:0] a, input logic way);
        outs_t o = e_miss();
        o.pmem_write         = 1'b1;
        o.pmem_address       = a;
        o.pmem_wdata_mux_sel = way;
        return o;
    endfunction

    function automatic outs_t e_rhit(input logic way, input logic stage);
        outs_t o = e_base();
        o.mem_resp         = 1'b1;
        o.load_lru         = 1'b1;
        o.lru_in           = ~way;
        o.line_out_mux_sel = way ? 2'b10 : 2'b01;
        o.load_stage       = stage;
        return o;
    endfunction

    function automatic outs_t e_whit(input logic way, input logic stage);
        outs_t o = e_base();
        o.mem_resp         = 1'b1;
        o.load_lru         = 1'b1;
        o.lru_in           = ~way;
        o.write_en_mux_sel = way ? 3'b110 : 3'b101;
        o.load_dirty       = way ? 2'b10 : 2'b01;
        o.dirty_in_mux_sel = 1'b1;
        o.load_stage       = stage;
        return o;
    endfunction

    function automatic void add(input ins_t i, input outs_t e, input string n);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
        names.push_back(n);
    endfunction

    task automatic drive(input ins_t x);
        rst                 = x.rst;
        mem_read            = x.mem_read;
        mem_write           = x.mem_write;
        mem_read_reg_out    = x.rd_reg;
        mem_write_reg_out   = x.wr_reg;
        mem_address_reg_out = x.addr;
        index_reg_out       = x.idx;
        hit                 = x.hit;
        dirty_out           = x.dirty;
        lru_out             = x.lru;
        tag_out             = {x.tag1, x.tag0};
        pmem_resp           = x.pmem_resp;
    endtask

    task automatic chk_int(input string n, input int a, input int e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Clean-victim miss with pmem_resp after n ALLOCATE cycles; response lands at n+2.
    task automatic miss_latency(input int n);
        ins_t x;
        int   resp_at;
        int   pulses;
        int   reads;
        x = '0;
        @(posedge clk); #1;
        x.mem_read = 1'b1;
        drive(x);
        @(posedge clk); #1;
        x.mem_read = 1'b0;
        x.rd_reg   = 1'b1;
        x.addr     = 32'h0000_2060;
        x.idx      = 3'd3;
        x.lru      = 1'b1;
        drive(x);
        resp_at = -1;
        pulses  = 0;
        reads   = 0;
        for (int cyc = 0; cyc < n + 8; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                hit = 2'b10;
                if (pmem_read) begin
                    reads++;
                    pmem_resp = (reads == n);
                end else begin
                    pmem_resp = 1'b0;
                end
            end
            #4;
            if (mem_resp) begin
                pulses++;
                if (resp_at < 0) resp_at = cyc;
            end
        end
        pmem_resp = 1'b0;
        hit       = 2'b00;
        chk_int($sformatf("lat%0d_resp_cycle", n), resp_at, n + 2);
        chk_int($sformatf("lat%0d_resp_pulses", n), pulses, 1);
        chk_int($sformatf("lat%0d_pmem_reads", n), reads, n);
    endtask

    initial begin
        ins_t  c;
        outs_t exp_o;

        // Cold read miss on way 0, then refill and hit.
        c = '0;
        add(c, e_base(), "reset_idle");
        c.mem_read = 1'b1;                       add(c, e_stage(), "cold_req");
        c.mem_read = 1'b0; c.rd_reg = 1'b1;
        c.addr = 32'h0000_0040; c.idx = 3'd2;    add(c, e_miss(), "cold_miss");
        add(c, e_alloc(32'h0000_0040), "cold_alloc0");
        add(c, e_alloc(32'h0000_0040), "cold_alloc1");
        c.pmem_resp = 1'b1;                      add(c, e_fill(32'h0000_0040, 1'b0), "cold_fill");
        c.pmem_resp = 1'b0;                      add(c, e_refill_vec(), "cold_refill");
        c.hit = 2'b01;                           add(c, e_rhit(1'b0, 1'b0), "cold_hit");
        c = '0; c.pmem_resp = 1'b1;              add(c, e_base(), "idle_stray_resp");

        // Back-to-back read hits in the same set, distinct ways.
        c = '0; c.mem_read = 1'b1;               add(c, e_stage(), "b2b_req");
        c.rd_reg = 1'b1; c.hit = 2'b01;          add(c, e_rhit(1'b0, 1'b1), "b2b_hit_way0");
        c.mem_read = 1'b0; c.hit = 2'b10;        add(c, e_rhit(1'b1, 1'b0), "b2b_hit_way1");

        // Write hits, including read+write staged together.
        c = '0; c.mem_write = 1'b1;              add(c, e_stage(), "whit_req");
        c.mem_write = 1'b0; c.wr_reg = 1'b1;
        c.hit = 2'b10;                           add(c, e_whit(1'b1, 1'b0), "whit_way1");
        c = '0; c.mem_read = 1'b1; c.mem_write = 1'b1;
        add(c, e_stage(), "rw_req");
        c.mem_read = 1'b0; c.mem_write = 1'b0;
        c.rd_reg = 1'b1; c.wr_reg = 1'b1; c.hit = 2'b01;
        add(c, e_whit(1'b0, 1'b0), "rw_as_write");

        // Dirty victim way 0: writeback, allocate, refill, hit.
        c = '0; c.mem_read = 1'b1;               add(c, e_stage(), "dirty0_req");
        c.mem_read = 1'b0; c.rd_reg = 1'b1;
        c.addr = 32'h1234_5640; c.idx = 3'd2; c.dirty = 2'b01;
        c.tag0 = 24'hABCDEF; c.tag1 = 24'h111111;
        add(c, e_miss(), "dirty0_miss");
        add(c, e_wb(32'hABCD_EF40, 1'b0), "dirty0_wb");
        c.pmem_resp = 1'b1;                      add(c, e_wb(32'hABCD_EF40, 1'b0), "dirty0_wb_done");
        add(c, e_fill(32'h1234_5640, 1'b0), "dirty0_fill");
        c.pmem_resp = 1'b0;                      add(c, e_refill_vec(), "dirty0_refill");
        c.hit = 2'b01;                           add(c, e_rhit(1'b0, 1'b0), "dirty0_hit");

        // Dirty victim way 1 on a write miss.
        c = '0; c.mem_write = 1'b1;              add(c, e_stage(), "dirty1_req");
        c.mem_write = 1'b0; c.wr_reg = 1'b1;
        c.addr = 32'h0000_0FA0; c.idx = 3'd5; c.dirty = 2'b10; c.lru = 1'b1;
        c.tag0 = 24'h222222; c.tag1 = 24'h000077;
        add(c, e_miss(), "dirty1_miss");
        c.pmem_resp = 1'b1;                      add(c, e_wb(32'h0000_77A0, 1'b1), "dirty1_wb");
        c.pmem_resp = 1'b0;                      add(c, e_alloc(32'h0000_0FA0), "dirty1_alloc");
        c.pmem_resp = 1'b1;                      add(c, e_fill(32'h0000_0FA0, 1'b1), "dirty1_fill");
        c.pmem_resp = 1'b0;                      add(c, e_refill_vec(), "dirty1_refill");
        c.hit = 2'b10;                           add(c, e_whit(1'b1, 1'b0), "dirty1_whit");

        // Reset in the middle of an allocate abandons the fill.
        c = '0; c.mem_read = 1'b1;               add(c, e_stage(), "rst_req");
        c.mem_read = 1'b0; c.rd_reg = 1'b1;
        c.addr = 32'h0000_0040; c.idx = 3'd2;    add(c, e_miss(), "rst_miss");
        c.rst = 1'b1;                            add(c, e_alloc(32'h0000_0040), "rst_in_alloc");
        c.rst = 1'b0; c.pmem_resp = 1'b1;        add(c, e_base(), "rst_idle_stray");
        c.pmem_resp = 1'b0;                      add(c, e_base(), "rst_idle_hold");

        c = '0;
        c.rst = 1'b1;
        drive(c);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].i);
            sb.push_back(vecs[i].e);
            #4;
            exp_o = sb.pop_front();
            tests++;
            if (act !== exp_o) begin
                fails++;
                $display("FAIL %s: got %h expected %h", names[i], act, exp_o);
            end
        end

        miss_latency(1);
        miss_latency(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic outs_t e_refill_vec();
        return e_miss();
    endfunction

endmodule

`default_nettype wire

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameters: s_index, default 3, set-index width; s_tag, default 24, tag width; s_offset, default 5, line-offset width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_read, mem_write  in  1 each  incoming (unstaged) CPU request.
REQ-005 mem_read_reg_out, mem_write_reg_out  in  1 each  staged request.
REQ-006 mem_address_reg_out  in  32  staged address; index_reg_out  in  3  staged set index.
REQ-007 hit  in  2  per-way hit; dirty_out  in  2  per-way dirty; lru_out  in  1  LRU way of the set.
REQ-008 tag_out  in  2x24  per-way stored tag.
REQ-009 pmem_resp  in  1  physical-memory completion strobe.
REQ-010 mem_resp  out  1  CPU request complete.
REQ-011 pmem_read, pmem_write  out  1 each; pmem_address  out  32, line-aligned.
REQ-012 load_stage, rindex_mux_sel  out  1 each  stage-register load; read-index select (0 incoming, 1 staged).
REQ-013 data_read_in, tag_read_in, valid_read_in, dirty_read_in  out  2 each; lru_read_in  out  1; array read enables.
REQ-014 load_tag, load_valid, load_dirty  out  2 each; load_lru, lru_in  out  1 each.
REQ-015 line_in_mux_sel  out  1 (0 CPU, 1 pmem); line_out_mux_sel  out  2; dirty_in_mux_sel  out  1; pmem_wdata_mux_sel  out  1; write_en_mux_sel  out  3.

Function
REQ-016 States: IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL; every output is 0 unless stated; read enables are constantly all-ones.
REQ-017 Victim way v = lru_out; arrays are not written with LRU during a miss, so v is stable from COMPARE-miss until REFILL.
REQ-018 IDLE: rindex_mux_sel=0; if mem_read|mem_write, load_stage=1 and go to COMPARE; else stay.
REQ-019 COMPARE with hit!=00: mem_resp=1; load_lru=1, lru_in=hit[0]; read: line_out_mux_sel=hit; write: write_en_mux_sel=3'b101 (way0) or 3'b110 (way1), load_dirty[way]=1, dirty_in_mux_sel=1.
REQ-020 COMPARE hit, pipelining: rindex_mux_sel=0, load_stage=mem_read|mem_write; next COMPARE if new request else IDLE; back-to-back hits complete one per cycle.
REQ-021 COMPARE with hit==00: mem_resp=0, load_stage=0, rindex_mux_sel=1; next WRITEBACK if dirty_out[v] else ALLOCATE.
REQ-022 WRITEBACK: pmem_write=1, pmem_wdata_mux_sel=v, pmem_address={tag_out[v], index_reg_out, 5'b0}; on pmem_resp go ALLOCATE.
REQ-023 ALLOCATE: pmem_read=1, pmem_address={mem_address_reg_out[31:5], 5'b0}; on pmem_resp: line_in_mux_sel=1, write_en_mux_sel=3'b001 (v=0) or 3'b010 (v=1), load_tag[v]=load_valid[v]=load_dirty[v]=1, dirty_in_mux_sel=0, go REFILL.
REQ-024 REFILL: one cycle, rindex_mux_sel=1 to re-read the staged set; go COMPARE, which then hits and responds.
REQ-025 In all non-IDLE/COMPARE states rindex_mux_sel=1, load_stage=0; staged request held.
REQ-026 Both staged read and write high: treated as write.
REQ-027 pmem_resp outside WRITEBACK/ALLOCATE is ignored; pmem_read/pmem_write held high until pmem_resp.
REQ-028 Miss latency with clean victim: COMPARE + ALLOCATE(n) + REFILL + COMPARE; mem_resp exactly one cycle per request.

Reset
REQ-029 rst high at a clock edge: state=IDLE, all outputs 0 except read enables; any pending pmem transaction abandoned (pmem_read/pmem_write low the next cycle).

Structure
REQ-030 Package cache_types_pkg holds: state enum, write_en_mux_sel encodings (NONE=000, LINE0=001, LINE1=010, BYTE0=101, BYTE1=110), line_out_mux_sel encodings.
REQ-031 Single module: state register plus combinational next-state/output logic; no sub-module.

Verification
REQ-032 Cold read 0x0000_0040, pmem_resp after 3 cycles -> pmem_read addr 0x0000_0040, load_valid[0], REFILL, then one mem_resp, lru_in=1.
REQ-033 Two consecutive read hits, same set, distinct ways -> mem_resp on two consecutive cycles, line_out_mux_sel 01 then 10.
REQ-034 Write hit way1, byte_enable 0x0000_000F -> write_en_mux_sel=110, load_dirty[1]=1, dirty_in_mux_sel=1, lru_in=0.
REQ-035 Miss with dirty victim way0, tag 0xABCDEF, index 2 -> pmem_write addr 0xABCD_EF40, then pmem_read of the new line, then mem_resp.
REQ-036 rst asserted during ALLOCATE -> next cycle state IDLE, pmem_read=0, mem_resp=0; stray pmem_resp ignored.
